// File: rtl/cfg_axil_initiator_pkg.sv
// Shared constants for the AXI-lite config initiator: response codes, FSM
// state encoding and the default per-transaction timeout.
package cfg_axil_initiator_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  localparam int TIMEOUT_CYCLES_DEFAULT = 5000;

  // States in which a bus transaction is outstanding and the timeout runs.
  function automatic logic is_bus_state(input logic [2:0] st);
    return (st == ST_WR_REQ) || (st == ST_WR_RESP) ||
           (st == ST_RD_REQ) || (st == ST_RD_RESP);
  endfunction

endpackage

// File: rtl/cfg_axil_initiator_if.sv
// AXI-lite (single-beat, 32-bit data) config bus between an initiator
// (master modport) and a peripheral register block (slave modport).
interface cfg_axil_initiator_if #(
  parameter int ADDR_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_timeout_cnt.sv
// Saturating per-transaction cycle counter; expire is high on the LIMIT-th
// enabled cycle after clear (and stays high while enabled). LIMIT = 0 disables.
module axil_timeout_cnt #(
  parameter int CNT_W = 16,
  parameter int LIMIT = 5000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // >= rather than == so a timeout still fires after a phase change that
  // consumed the exact expiry cycle.
  assign expire_o = (LIMIT != 0) && enable_i && (cnt_q >= LIMIT_M1);

endmodule

// File: rtl/cfg_axil_initiator.sv
// Command/response to AXI-lite single-beat initiator with per-transaction timeout.
// Handshakes: a transfer occurs on a rising clk_i edge where valid && ready; a
// valid, once raised, holds with stable payload until that edge.
module cfg_axil_initiator
  import cfg_axil_initiator_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  input  logic [3:0]            cmd_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  output logic                  rsp_timeout_o,
  output logic                  busy_o,
  output logic [2:0]            state_o,
  cfg_axil_initiator_if.master  cfg
);

  logic [2:0] state_q;
  logic       aw_done_q, w_done_q;
  logic       aw_fire, w_fire, aw_done_n, w_done_n;
  logic       progress, expire, abort, cmd_fire;

  assign state_o  = state_q;
  assign cmd_fire = (state_q == ST_IDLE) && cmd_valid_i;

  always_comb begin
    aw_fire   = cfg.awvalid && cfg.awready;
    w_fire    = cfg.wvalid && cfg.wready;
    aw_done_n = aw_done_q || aw_fire;
    w_done_n  = w_done_q || w_fire;
    progress  = 1'b0;
    case (state_q)
      ST_WR_REQ:  progress = aw_done_n && w_done_n;
      ST_WR_RESP: progress = cfg.bvalid;
      ST_RD_REQ:  progress = cfg.arready;
      ST_RD_RESP: progress = cfg.rvalid;
      default:    progress = 1'b0;
    endcase
    // A handshake landing on the expiry cycle takes priority over the abort.
    abort = expire && !progress;
  end

  axil_timeout_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (cmd_fire),
    .enable_i (is_bus_state(state_q)),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cmd_ready_o   <= 1'b1;
      busy_o        <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_resp_o    <= RESP_OKAY;
      rsp_timeout_o <= 1'b0;
      cfg.awvalid   <= 1'b0;
      cfg.awaddr    <= '0;
      cfg.wvalid    <= 1'b0;
      cfg.wdata     <= '0;
      cfg.wstrb     <= '0;
      cfg.bready    <= 1'b1;
      cfg.arvalid   <= 1'b0;
      cfg.araddr    <= '0;
      cfg.rready    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // bready/rready stay high here so stale responses drain silently.
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (cmd_write_i) begin
              cfg.awaddr  <= cmd_addr_i;
              cfg.wdata   <= cmd_wdata_i;
              cfg.wstrb   <= cmd_wstrb_i;
              cfg.awvalid <= 1'b1;
              cfg.wvalid  <= 1'b1;
              cfg.rready  <= 1'b0;
              aw_done_q   <= 1'b0;
              w_done_q    <= 1'b0;
              state_q     <= ST_WR_REQ;
            end else begin
              cfg.araddr  <= cmd_addr_i;
              cfg.arvalid <= 1'b1;
              cfg.bready  <= 1'b0;
              state_q     <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (aw_fire) cfg.awvalid <= 1'b0;
          if (w_fire)  cfg.wvalid  <= 1'b0;
          aw_done_q <= aw_done_n;
          w_done_q  <= w_done_n;
          if (aw_done_n && w_done_n) state_q <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (cfg.bvalid) begin
            rsp_resp_o    <= cfg.bresp;
            rsp_rdata_o   <= '0;
            rsp_timeout_o <= 1'b0;
            rsp_valid_o   <= 1'b1;
            cfg.bready    <= 1'b0;
            state_q       <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (cfg.arready) begin
            cfg.arvalid <= 1'b0;
            state_q     <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (cfg.rvalid) begin
            rsp_rdata_o   <= cfg.rdata;
            rsp_resp_o    <= cfg.rresp;
            rsp_timeout_o <= 1'b0;
            rsp_valid_o   <= 1'b1;
            cfg.rready    <= 1'b0;
            state_q       <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o   <= 1'b0;
            rsp_timeout_o <= 1'b0;
            cmd_ready_o   <= 1'b1;
            busy_o        <= 1'b0;
            cfg.bready    <= 1'b1;
            cfg.rready    <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (abort) begin
        cfg.awvalid   <= 1'b0;
        cfg.wvalid    <= 1'b0;
        cfg.arvalid   <= 1'b0;
        cfg.bready    <= 1'b0;
        cfg.rready    <= 1'b0;
        rsp_valid_o   <= 1'b1;
        rsp_rdata_o   <= '0;
        rsp_resp_o    <= RESP_SLVERR;
        rsp_timeout_o <= 1'b1;
        state_q       <= ST_RSP;
      end
    end
  end

endmodule

// File: tb/tb_cfg_axil_initiator.sv
// Directed bench for cfg_axil_initiator with a configurable reactive AXI-lite slave.
module tb_cfg_axil_initiator;
  import cfg_axil_initiator_pkg::*;

  localparam int TMO = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready;
  logic        rsp_valid, rsp_timeout, busy;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [2:0]  state;

  cfg_axil_initiator_if #(.ADDR_W(32)) bus ();

  cfg_axil_initiator #(
    .ADDR_W(32), .TIMEOUT_CYCLES(TMO), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout), .busy_o(busy),
    .state_o(state), .cfg(bus)
  );

  // ---------------- slave model ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
  bit b_never = 1'b0, stale_req = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  bit aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    end else begin
      if (bus.bvalid && bus.bready) begin b_cnt++; b_pend = 0; end
      if (bus.rvalid && bus.rready) begin r_cnt++; r_pend = 0; end
      if (bus.awvalid && bus.awready) begin aw_cnt++; aw_got = 1; end
      if (bus.wvalid && bus.wready) begin w_cnt++; w_got = 1; end
      if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0; end
      if (bus.arvalid && bus.arready) begin ar_cnt++; r_pend = 1; r_wait = 0; end
    end
  end

  always @(negedge clk) begin
    bus.awready = bus.awvalid && (aw_wait >= aw_delay);
    aw_wait     = bus.awvalid ? aw_wait + 1 : 0;
    bus.wready  = bus.wvalid && (w_wait >= w_delay);
    w_wait      = bus.wvalid ? w_wait + 1 : 0;
    bus.arready = bus.arvalid && (ar_wait >= ar_delay);
    ar_wait     = bus.arvalid ? ar_wait + 1 : 0;
    bus.bvalid  = (b_pend && !b_never && (b_wait >= b_delay)) || stale_req;
    bus.bresp   = stale_req ? 2'b11 : b_resp_cfg;
    stale_req   = 1'b0;
    if (b_pend) b_wait++;
    bus.rvalid  = r_pend && (r_wait >= r_delay);
    bus.rdata   = r_data_cfg;
    bus.rresp   = r_resp_cfg;
    if (r_pend) r_wait++;
  end

  // ---------------- checking ----------------
  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // per-cycle history of the last transaction, index = cycles after accept
  logic        aw_hist[64], w_hist[64], ar_hist[64];
  logic [31:0] seen_awaddr, seen_wdata, seen_araddr;
  logic [3:0]  seen_wstrb;

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input int hold,
                     output logic [31:0] rdata, output logic [1:0] resp,
                     output logic tmo, output int lat);
    bit got;
    for (int i = 0; i < 64; i++) begin aw_hist[i] = 0; w_hist[i] = 0; ar_hist[i] = 0; end
    step();
    check("cmd_ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    @(posedge clk);
    got = 0; lat = -1;
    for (int n = 1; n < 64 && !got; n++) begin
      step();
      cmd_valid = 1'b0;
      aw_hist[n] = bus.awvalid; w_hist[n] = bus.wvalid; ar_hist[n] = bus.arvalid;
      if (n == 1) begin
        seen_awaddr = bus.awaddr; seen_wdata = bus.wdata;
        seen_wstrb = bus.wstrb; seen_araddr = bus.araddr;
      end
      if (rsp_valid) begin got = 1; lat = n; end
    end
    check("rsp_within_bound", got, 1'b1);
    rdata = rsp_rdata; resp = rsp_resp; tmo = rsp_timeout;
    for (int h = 0; h < hold; h++) begin
      step();
      check("rsp_held_until_ready", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout},
            {1'b1, rdata, resp, tmo});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_dropped", rsp_valid, 1'b0);
    check("rsp_timeout_cleared", rsp_timeout, 1'b0);
    check("cmd_ready_after_rsp", cmd_ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        to;
    int          lat, a0, w0, ar0, b0;

    repeat (3) step();
    // reset values
    check("rst_state", state, ST_IDLE);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_bready", bus.bready, 1'b1);
    check("rst_rready", bus.rready, 1'b1);
    check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid}, 4'b0000);
    check("rst_payload", {bus.awaddr, bus.wdata, bus.wstrb, bus.araddr, rsp_rdata, rsp_resp},
          '0);
    check("rst_timeout_busy", {rsp_timeout, busy}, 2'b00);
    rst_n = 1'b1;

    // 1: CTRL0 write, zero-wait slave
    a0 = aw_cnt; w0 = w_cnt;
    txn(1'b1, 32'h4000_1000, 32'h0000_000E, 4'hF, 2, rd, rs, to, lat);
    check("wr0_latency", lat, 3);
    check("wr0_resp", rs, 2'b00);
    check("wr0_rdata", rd, 32'h0);
    check("wr0_timeout", to, 1'b0);
    check("wr0_aw_payload", {seen_awaddr, seen_wdata, seen_wstrb},
          {32'h4000_1000, 32'h0000_000E, 4'hF});
    check("wr0_aw_w_cycle1", {aw_hist[1], w_hist[1], aw_hist[2], w_hist[2]}, 4'b1100);
    check("wr0_beats", {16'(aw_cnt - a0), 16'(w_cnt - w0)}, {16'd1, 16'd1});

    // 2a: AWREADY two cycles ahead of WREADY
    w_delay = 2; a0 = aw_cnt; w0 = w_cnt;
    txn(1'b1, 32'h4000_1008, 32'hA5A5_0001, 4'h3, 0, rd, rs, to, lat);
    check("wr_awfirst_latency", lat, 5);
    check("wr_awfirst_resp", rs, 2'b00);
    check("wr_awfirst_valids_c2", {aw_hist[2], w_hist[2]}, 2'b01);
    check("wr_awfirst_valids_c4", {aw_hist[4], w_hist[4]}, 2'b00);
    check("wr_awfirst_beats", {16'(aw_cnt - a0), 16'(w_cnt - w0)}, {16'd1, 16'd1});

    // 2b: reversed
    w_delay = 0; aw_delay = 2; a0 = aw_cnt; w0 = w_cnt;
    txn(1'b1, 32'h4000_100C, 32'h1234_5678, 4'hF, 0, rd, rs, to, lat);
    check("wr_wfirst_latency", lat, 5);
    check("wr_wfirst_resp", rs, 2'b00);
    check("wr_wfirst_valids_c2", {aw_hist[2], w_hist[2]}, 2'b10);
    check("wr_wfirst_beats", {16'(aw_cnt - a0), 16'(w_cnt - w0)}, {16'd1, 16'd1});
    aw_delay = 0;

    // 3: PRESCALE0 read, RVALID delayed 4 cycles
    r_delay = 4; r_data_cfg = 32'h0000_0001; ar0 = ar_cnt;
    txn(1'b0, 32'h4000_1004, 32'h0, 4'h0, 1, rd, rs, to, lat);
    check("rd_latency", lat, 7);
    check("rd_rdata", rd, 32'h0000_0001);
    check("rd_resp", rs, 2'b00);
    check("rd_araddr", seen_araddr, 32'h4000_1004);
    check("rd_arvalid_one_cycle", {ar_hist[1], ar_hist[2]}, 2'b10);
    check("rd_ar_beats", ar_cnt - ar0, 1);
    r_delay = 0;

    // 4: write with no B response -> timeout
    b_never = 1'b1;
    txn(1'b1, 32'h4000_1010, 32'hFFFF_FFFF, 4'hF, 1, rd, rs, to, lat);
    check("wr_tmo_latency", lat, TMO + 1);
    check("wr_tmo_resp", rs, 2'b10);
    check("wr_tmo_flag", to, 1'b1);
    check("wr_tmo_rdata", rd, 32'h0);
    check("wr_tmo_valids_low", {aw_hist[TMO+1], w_hist[TMO+1], ar_hist[TMO+1]}, 3'b000);

    // 5: the late B and an extra stale pulse arrive in IDLE and are dropped
    b_resp_cfg = 2'b11; b_never = 1'b0; b0 = b_cnt;
    repeat (4) step();
    check("late_b_absorbed", b_cnt - b0, 1);
    check("late_b_no_rsp", {rsp_valid, busy, state}, {1'b0, 1'b0, ST_IDLE});
    stale_req = 1'b1;
    repeat (3) step();
    check("stale_b_absorbed", b_cnt - b0, 2);
    check("stale_b_no_rsp", rsp_valid, 1'b0);
    b_resp_cfg = 2'b10;
    txn(1'b1, 32'h4000_1000, 32'h0000_0001, 4'h1, 0, rd, rs, to, lat);
    check("wr_after_stale_resp", rs, 2'b10);
    check("wr_after_stale_tmo", to, 1'b0);
    check("wr_after_stale_latency", lat, 3);
    b_resp_cfg = 2'b00;

    // 6: read whose AR is never accepted -> timeout, AR dropped
    ar_delay = 100; r_data_cfg = 32'hCAFE_F00D; ar0 = ar_cnt;
    txn(1'b0, 32'h4000_1020, 32'h0, 4'h0, 0, rd, rs, to, lat);
    check("rd_tmo_latency", lat, TMO + 1);
    check("rd_tmo_resp_rdata", {rs, to, rd}, {2'b10, 1'b1, 32'h0});
    check("rd_tmo_arvalid", {ar_hist[TMO], ar_hist[TMO+1]}, 2'b10);
    check("rd_tmo_no_ar_beat", ar_cnt - ar0, 0);
    ar_delay = 0;

    // 7: reset while in RD_RESP
    r_delay = 50;
    step();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_1004;
    @(posedge clk);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("mid_rd_state", state, ST_RD_RESP);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_state", state, ST_IDLE);
    check("rst_mid_outputs", {bus.arvalid, rsp_valid, cmd_ready, busy}, 4'b0010);
    step();
    rst_n = 1'b1;
    r_delay = 0;
    repeat (3) step();
    check("rst_mid_no_rsp", rsp_valid, 1'b0);

    // 8: recovery read after reset
    r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = 2'b01;
    txn(1'b0, 32'h4000_1004, 32'h0, 4'h0, 0, rd, rs, to, lat);
    check("rd_recover", {rd, rs, to}, {32'hDEAD_BEEF, 2'b01, 1'b0});
    check("rd_recover_latency", lat, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

endmodule
